// File: rtl/game_flow_ctrl_if.sv
// game_flow_ctrl_if: signal bundle between the game flow sequencer and its
// surroundings (keyboard decoder, obstacle_column, HUD).
//   start_key       - key level from the keyboard decoder
//   will_collide    - collision level from obstacle_column
//   passed_through  - pass level from obstacle_column (multi-frame high)
//   start_moving    - one-frame start kick to obstacle_column
//   column_reset    - one-frame re-init request after death
//   game_state      - 00 IDLE, 01 RUN, 10 DEAD
//   gravity_flip    - 0 normal, 1 inverted gravity
//   score_bcd       - current score, packed BCD, LS digit in [3:0]
//   high_score_bcd  - best score since reset, packed BCD
// master: the sequencer side; slave: the environment side.
interface game_flow_ctrl_if #(
    parameter int unsigned SCORE_DIGITS = 3
);
    logic                        start_key;
    logic                        will_collide;
    logic                        passed_through;
    logic                        start_moving;
    logic                        column_reset;
    logic [1:0]                  game_state;
    logic                        gravity_flip;
    logic [4*SCORE_DIGITS-1:0]   score_bcd;
    logic [4*SCORE_DIGITS-1:0]   high_score_bcd;

    modport master (
        input  start_key, will_collide, passed_through,
        output start_moving, column_reset, game_state, gravity_flip,
               score_bcd, high_score_bcd
    );

    modport slave (
        output start_key, will_collide, passed_through,
        input  start_moving, column_reset, game_state, gravity_flip,
               score_bcd, high_score_bcd
    );
endinterface

// File: rtl/game_flow_ctrl.sv
// game_flow_ctrl: per-frame game sequencer downstream of obstacle_column.
// Owns the IDLE/RUN/DEAD flow, emits the start kick and post-death re-init
// pulse, tracks gravity orientation and keeps BCD score / high score.
//   frame_clk - frame clock, all state changes on its rising edge
//   Reset     - asynchronous, active-high
//   gfc       - game_flow_ctrl_if.master (inputs from keyboard/obstacle,
//               registered outputs to obstacle_column and HUD)
module game_flow_ctrl #(
    parameter int unsigned SCORE_DIGITS = 3,
    parameter int unsigned DEATH_FRAMES = 60,
    parameter int unsigned FLIP_EVERY   = 1
) (
    input  logic                    frame_clk,
    input  logic                    Reset,
    game_flow_ctrl_if.master        gfc
);
    localparam int unsigned SW = 4 * SCORE_DIGITS;
    localparam int unsigned TW = (DEATH_FRAMES > 1) ? $clog2(DEATH_FRAMES) : 1;
    localparam int unsigned CW = $clog2(FLIP_EVERY + 1);
    localparam logic [TW-1:0] T_LOAD = TW'(DEATH_FRAMES - 1);
    localparam logic [CW-1:0] C_TOP  = CW'(FLIP_EVERY);
    localparam logic [SW-1:0] ALL9   = {SCORE_DIGITS{4'h9}};

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        DEAD = 2'b10
    } state_t;

    state_t          state;
    logic            key_prev;
    logic            pass_prev;
    logic            start_moving;
    logic            column_reset;
    logic            gravity_flip;
    logic [SW-1:0]   score;
    logic [SW-1:0]   high_score;
    logic [CW-1:0]   pass_cnt;
    logic [TW-1:0]   death_timer;

    logic            key_edge;
    logic            pass_edge;
    logic [CW-1:0]   pass_cnt_next;

    // BCD +1 with per-digit carry; a score of all 9s saturates.
    function automatic logic [SW-1:0] bcd_inc(input logic [SW-1:0] v);
        logic [SW-1:0] r;
        logic          carry;
        r     = v;
        carry = 1'b1;
        if (v != ALL9) begin
            for (int unsigned i = 0; i < SCORE_DIGITS; i++) begin
                if (carry) begin
                    if (r[4*i +: 4] == 4'd9) begin
                        r[4*i +: 4] = 4'd0;
                    end else begin
                        r[4*i +: 4] = r[4*i +: 4] + 4'd1;
                        carry       = 1'b0;
                    end
                end
            end
        end
        return r;
    endfunction

    assign key_edge      = gfc.start_key & ~key_prev;
    assign pass_edge     = gfc.passed_through & ~pass_prev;
    assign pass_cnt_next = pass_cnt + CW'(1);

    always_ff @(posedge frame_clk or posedge Reset) begin
        if (Reset) begin
            state        <= IDLE;
            // Prev registers reset high so a level already present at
            // reset release does not count as a fresh press/pass.
            key_prev     <= 1'b1;
            pass_prev    <= 1'b1;
            start_moving <= 1'b0;
            column_reset <= 1'b0;
            gravity_flip <= 1'b0;
            score        <= '0;
            high_score   <= '0;
            pass_cnt     <= '0;
            death_timer  <= '0;
        end else begin
            key_prev     <= gfc.start_key;
            pass_prev    <= gfc.passed_through;
            start_moving <= 1'b0;
            column_reset <= 1'b0;
            case (state)
                IDLE: begin
                    if (key_edge) begin
                        state        <= RUN;
                        start_moving <= 1'b1;
                        score        <= '0;
                        pass_cnt     <= '0;
                        gravity_flip <= 1'b0;
                    end
                end
                RUN: begin
                    // Collision wins over a pass in the same frame.
                    if (gfc.will_collide) begin
                        state       <= DEAD;
                        death_timer <= T_LOAD;
                        if (score > high_score) begin
                            high_score <= score;
                        end
                    end else if (pass_edge) begin
                        score <= bcd_inc(score);
                        if (pass_cnt_next == C_TOP) begin
                            gravity_flip <= ~gravity_flip;
                            pass_cnt     <= '0;
                        end else begin
                            pass_cnt <= pass_cnt_next;
                        end
                    end
                end
                DEAD: begin
                    // Presses during the countdown are dropped, not queued.
                    if (death_timer != '0) begin
                        death_timer <= death_timer - TW'(1);
                    end else if (key_edge) begin
                        state        <= IDLE;
                        column_reset <= 1'b1;
                    end
                end
                default: begin
                    state        <= IDLE;
                    gravity_flip <= 1'b0;
                    score        <= '0;
                    pass_cnt     <= '0;
                    death_timer  <= '0;
                end
            endcase
        end
    end

    assign gfc.game_state     = state;
    assign gfc.start_moving   = start_moving;
    assign gfc.column_reset   = column_reset;
    assign gfc.gravity_flip   = gravity_flip;
    assign gfc.score_bcd      = score;
    assign gfc.high_score_bcd = high_score;
endmodule

// File: tb/tb_game_flow_ctrl.sv
// tb_game_flow_ctrl: self-checking bench for game_flow_ctrl
// (SCORE_DIGITS=3, DEATH_FRAMES=60, FLIP_EVERY=1). Vector table, directed
// multi-cycle sequences, then random stimulus against a reference model.
module tb_game_flow_ctrl;
    localparam int unsigned SD    = 3;
    localparam int unsigned DF    = 60;
    localparam int unsigned FE    = 1;
    localparam int          MAXS  = 999;

    logic clk;
    logic rst;

    game_flow_ctrl_if #(.SCORE_DIGITS(SD)) bus ();

    game_flow_ctrl #(
        .SCORE_DIGITS (SD),
        .DEATH_FRAMES (DF),
        .FLIP_EVERY   (FE)
    ) dut (
        .frame_clk (clk),
        .Reset     (rst),
        .gfc       (bus.master)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: game mode, total scored passes since start, frames
    // spent dead, best score as plain integers.
    int m_mode;      // 0 idle, 1 running, 2 dead
    int m_passes;
    int m_dead;
    int m_hi;
    bit m_pk, m_pp, m_sm, m_cr;

    function automatic int m_score();
        return (m_passes > MAXS) ? MAXS : m_passes;
    endfunction

    function automatic logic [11:0] to_bcd(input int v);
        logic [11:0] r;
        int t;
        t = v;
        r = '0;
        for (int i = 0; i < 3; i++) begin
            r[4*i +: 4] = 4'(t % 10);
            t = t / 10;
        end
        return r;
    endfunction

    function automatic void model_step();
        bit ke, pe;
        if (rst) begin
            m_mode = 0; m_passes = 0; m_dead = 0; m_hi = 0;
            m_pk = 1'b1; m_pp = 1'b1; m_sm = 1'b0; m_cr = 1'b0;
            return;
        end
        ke = bus.start_key & !m_pk;
        pe = bus.passed_through & !m_pp;
        m_pk = bus.start_key;
        m_pp = bus.passed_through;
        m_sm = 1'b0;
        m_cr = 1'b0;
        case (m_mode)
            0: if (ke) begin m_mode = 1; m_passes = 0; m_sm = 1'b1; end
            1: begin
                if (bus.will_collide) begin
                    m_mode = 2;
                    m_dead = 0;
                    if (m_score() > m_hi) m_hi = m_score();
                end else if (pe) begin
                    m_passes++;
                end
            end
            default: begin
                m_dead++;
                if (ke && m_dead >= DF) begin m_mode = 0; m_cr = 1'b1; end
            end
        endcase
    endfunction

    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_model();
        check("m_state", 32'(bus.game_state), 32'(m_mode));
        check("m_start_moving", 32'(bus.start_moving), 32'(m_sm));
        check("m_column_reset", 32'(bus.column_reset), 32'(m_cr));
        check("m_gravity", 32'(bus.gravity_flip), 32'((m_passes / FE) % 2));
        check("m_score", 32'(bus.score_bcd), 32'(to_bcd(m_score())));
        check("m_high", 32'(bus.high_score_bcd), 32'(to_bcd(m_hi)));
        check("m_no_overlap", 32'(bus.start_moving & bus.column_reset), 32'(0));
    endtask

    task automatic do_reset();
        rst = 1'b1;
        bus.start_key = 1'b0; bus.will_collide = 1'b0; bus.passed_through = 1'b0;
        tick();
        rst = 1'b0;
        tick();
    endtask

    task automatic start_game();
        bus.start_key = 1'b1; tick();
        bus.start_key = 1'b0; tick();
    endtask

    task automatic short_pass();
        bus.passed_through = 1'b1; tick();
        bus.passed_through = 1'b0; tick();
    endtask

    typedef struct {
        logic        rst, key, col, pas;
        logic [1:0]  st;
        logic        sm, cr, flip;
        logic [11:0] score, hi;
    } vec_t;

    vec_t tbl[13];

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        //            rst  key  col  pas  st     sm   cr   flip score    hi
        tbl[0]  = '{1'b1,1'b1,1'b0,1'b0,2'b00,1'b0,1'b0,1'b0,12'h000,12'h000};
        tbl[1]  = '{1'b0,1'b1,1'b0,1'b0,2'b00,1'b0,1'b0,1'b0,12'h000,12'h000};
        tbl[2]  = '{1'b0,1'b0,1'b0,1'b0,2'b00,1'b0,1'b0,1'b0,12'h000,12'h000};
        tbl[3]  = '{1'b0,1'b1,1'b0,1'b0,2'b01,1'b1,1'b0,1'b0,12'h000,12'h000};
        tbl[4]  = '{1'b0,1'b1,1'b0,1'b0,2'b01,1'b0,1'b0,1'b0,12'h000,12'h000};
        tbl[5]  = '{1'b0,1'b1,1'b0,1'b1,2'b01,1'b0,1'b0,1'b1,12'h001,12'h000};
        tbl[6]  = '{1'b0,1'b1,1'b0,1'b1,2'b01,1'b0,1'b0,1'b1,12'h001,12'h000};
        tbl[7]  = '{1'b0,1'b1,1'b0,1'b0,2'b01,1'b0,1'b0,1'b1,12'h001,12'h000};
        tbl[8]  = '{1'b0,1'b1,1'b0,1'b1,2'b01,1'b0,1'b0,1'b0,12'h002,12'h000};
        tbl[9]  = '{1'b0,1'b0,1'b0,1'b0,2'b01,1'b0,1'b0,1'b0,12'h002,12'h000};
        tbl[10] = '{1'b0,1'b1,1'b0,1'b0,2'b01,1'b0,1'b0,1'b0,12'h002,12'h000};
        tbl[11] = '{1'b0,1'b1,1'b1,1'b1,2'b10,1'b0,1'b0,1'b0,12'h002,12'h002};
        tbl[12] = '{1'b0,1'b0,1'b0,1'b0,2'b10,1'b0,1'b0,1'b0,12'h002,12'h002};

        rst = 1'b1;
        bus.start_key = 1'b0; bus.will_collide = 1'b0; bus.passed_through = 1'b0;

        for (int i = 0; i < 13; i++) begin
            rst = tbl[i].rst;
            bus.start_key = tbl[i].key;
            bus.will_collide = tbl[i].col;
            bus.passed_through = tbl[i].pas;
            tick();
            check($sformatf("tbl%0d_state", i), 32'(bus.game_state), 32'(tbl[i].st));
            check($sformatf("tbl%0d_start", i), 32'(bus.start_moving), 32'(tbl[i].sm));
            check($sformatf("tbl%0d_creset", i), 32'(bus.column_reset), 32'(tbl[i].cr));
            check($sformatf("tbl%0d_flip", i), 32'(bus.gravity_flip), 32'(tbl[i].flip));
            check($sformatf("tbl%0d_score", i), 32'(bus.score_bcd), 32'(tbl[i].score));
            check($sformatf("tbl%0d_high", i), 32'(bus.high_score_bcd), 32'(tbl[i].hi));
        end

        // Long passes: one score step and one gravity toggle per pass.
        do_reset();
        start_game();
        for (int p = 1; p <= 3; p++) begin
            bus.passed_through = 1'b1;
            tick();
            check("long_pass_score", 32'(bus.score_bcd), 32'(p));
            check("long_pass_flip", 32'(bus.gravity_flip), 32'(p % 2));
            repeat (7) tick();
            bus.passed_through = 1'b0;
            tick();
            check("long_pass_hold", 32'(bus.score_bcd), 32'(p));
        end

        // Digit carry and saturation.
        do_reset();
        start_game();
        for (int p = 1; p <= 1000; p++) begin
            short_pass();
            if (p == 9)    check("carry_009", 32'(bus.score_bcd), 32'h009);
            if (p == 10)   check("carry_010", 32'(bus.score_bcd), 32'h010);
            if (p == 999)  check("sat_999", 32'(bus.score_bcd), 32'h999);
            if (p == 1000) begin
                check("sat_hold", 32'(bus.score_bcd), 32'h999);
                check("sat_flip", 32'(bus.gravity_flip), 32'(0));
            end
        end

        // Collision beats a same-frame pass, then the death countdown.
        do_reset();
        start_game();
        repeat (5) short_pass();
        bus.will_collide = 1'b1; bus.passed_through = 1'b1;
        tick();
        bus.will_collide = 1'b0; bus.passed_through = 1'b0;
        check("coll_state", 32'(bus.game_state), 32'(2));
        check("coll_score", 32'(bus.score_bcd), 32'h005);
        check("coll_high", 32'(bus.high_score_bcd), 32'h005);
        repeat (29) tick();
        bus.start_key = 1'b1; tick();
        check("dead30_state", 32'(bus.game_state), 32'(2));
        check("dead30_creset", 32'(bus.column_reset), 32'(0));
        bus.start_key = 1'b0;
        repeat (28) tick();
        bus.start_key = 1'b1; tick();
        check("dead59_state", 32'(bus.game_state), 32'(2));
        check("dead59_creset", 32'(bus.column_reset), 32'(0));
        bus.start_key = 1'b0; tick();
        bus.start_key = 1'b1; tick();
        check("dead61_state", 32'(bus.game_state), 32'(0));
        check("dead61_creset", 32'(bus.column_reset), 32'(1));
        check("dead61_start", 32'(bus.start_moving), 32'(0));
        tick();
        check("creset_once", 32'(bus.column_reset), 32'(0));
        check("idle_score_hold", 32'(bus.score_bcd), 32'h005);
        bus.start_key = 1'b0; tick();
        bus.start_key = 1'b1; tick();
        check("restart_state", 32'(bus.game_state), 32'(1));
        check("restart_start", 32'(bus.start_moving), 32'(1));
        check("restart_score", 32'(bus.score_bcd), 32'h000);
        check("restart_high", 32'(bus.high_score_bcd), 32'h005);
        bus.start_key = 1'b0; tick();

        // Asynchronous reset mid-run.
        repeat (7) short_pass();
        check("pre_rst_score", 32'(bus.score_bcd), 32'h007);
        check("pre_rst_flip", 32'(bus.gravity_flip), 32'(1));
        rst = 1'b1;
        #1;
        check("arst_state", 32'(bus.game_state), 32'(0));
        check("arst_score", 32'(bus.score_bcd), 32'h000);
        check("arst_high", 32'(bus.high_score_bcd), 32'h000);
        check("arst_flip", 32'(bus.gravity_flip), 32'(0));
        check("arst_pulses", 32'({bus.start_moving, bus.column_reset}), 32'(0));
        tick();
        rst = 1'b0;

        // Random stimulus against the reference model.
        do_reset();
        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(0, 5) == 0) bus.start_key = ~bus.start_key;
            if ($urandom_range(0, 3) == 0) bus.passed_through = ~bus.passed_through;
            bus.will_collide = ($urandom_range(0, 59) == 0);
            rst = ($urandom_range(0, 999) == 0);
            tick();
            check_model();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
